ram_rr_arbiter: RTL and testbench

N-port round-robin arbiter that shares the single SDRAM read-request interface (23-bit address, 8-bit data, busy/in_valid/out_valid handshake) between several client blocks. It sits between the clients and the RAM controller. Each client sees a private request port with its own busy, response strobe and error strobe. It adds fair rotation between ports and a per-transaction response timeout.

---
 rtl/ram_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - round-robin arbiter sharing one RAM read-request port among N clients
module ram_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]            port_in_valid,
  output logic [NUM_PORTS-1:0]            port_busy,
  output logic [NUM_PORTS-1:0]            port_out_valid,
  output logic [NUM_PORTS-1:0]            port_error,
  output logic [DATA_WIDTH-1:0]           port_data_out,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic                            ram_in_valid,
  input  logic                            ram_busy,
  input  logic                            ram_out_valid,
  input  logic [DATA_WIDTH-1:0]           ram_data_out
);

  localparam int GW = $clog2(NUM_PORTS);
  // A disabled timeout still needs a legal (1-bit) timer vector.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [NUM_PORTS-1:0]  pending;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_PORTS];
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         next_grant;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         timer_next;
  logic [NUM_PORTS-1:0]  grant_onehot;
  logic [NUM_PORTS-1:0]  release_mask;
  logic                  timed_out;

  assign port_busy    = pending;
  assign grant_onehot = NUM_PORTS'(1) << grant;

  // Timer saturates at all-ones so a disabled timeout never wraps.
  assign timer_next = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;
  assign timed_out  = (TIMEOUT != 0) && (timer_next == TW'(TIMEOUT));

  // Transaction end (data or timeout) frees the granted port's pending bit.
  assign release_mask = ((state == S_WAIT) && (ram_out_valid || timed_out)) ? grant_onehot : '0;

  // Rotating priority: lowest pending index above last_grant, else lowest overall.
  always_comb begin
    next_grant = last_grant;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i] && (i <= int'(last_grant))) next_grant = GW'(i);
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(last_grant))) next_grant = GW'(i);
    end
  end

  // Per-port request capture; a busy port ignores new strobes and keeps its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NUM_PORTS; i++) addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (port_in_valid[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          addr_q[i]  <= port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end else if (release_mask[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Grant / issue / wait sequencing with one outstanding RAM transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      grant          <= '0;
      last_grant     <= GW'(NUM_PORTS - 1);
      timer          <= '0;
      ram_addr       <= '0;
      ram_in_valid   <= 1'b0;
      port_out_valid <= '0;
      port_error     <= '0;
      port_data_out  <= '0;
    end else begin
      ram_in_valid   <= 1'b0;
      port_out_valid <= '0;
      port_error     <= '0;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            grant <= next_grant;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!ram_busy) begin
            ram_addr     <= addr_q[grant];
            ram_in_valid <= 1'b1;
            timer        <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer_next;
          if (ram_out_valid) begin
            port_data_out  <= ram_data_out;
            port_out_valid <= grant_onehot;
            last_grant     <= grant;
            state          <= S_IDLE;
          end else if (timed_out) begin
            port_error <= grant_onehot;
            last_grant <= grant;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb/tb_ram_rr_arbiter.sv - self-checking bench for ram_rr_arbiter
module tb_ram_rr_arbiter;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*AW-1:0] port_addr = '0;
  logic [NP-1:0]    port_in_valid = '0;
  logic [NP-1:0]    port_busy;
  logic [NP-1:0]    port_out_valid;
  logic [NP-1:0]    port_error;
  logic [DW-1:0]    port_data_out;
  logic [AW-1:0]    ram_addr;
  logic             ram_in_valid;
  logic             ram_busy = 1'b0;
  logic             ram_out_valid = 1'b0;
  logic [DW-1:0]    ram_data_out = '0;

  ram_rr_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .port_addr(port_addr), .port_in_valid(port_in_valid),
    .port_busy(port_busy), .port_out_valid(port_out_valid), .port_error(port_error),
    .port_data_out(port_data_out), .ram_addr(ram_addr), .ram_in_valid(ram_in_valid),
    .ram_busy(ram_busy), .ram_out_valid(ram_out_valid), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which client owns the RAM, whether its request went out, and its age.
  bit            m_valid = 0;
  logic [NP-1:0] m_pending;
  logic [AW-1:0] m_addr [NP];
  int            m_last, m_owner, m_age;
  bit            m_active, m_issued;
  logic [NP-1:0] e_ov, e_err;
  logic [DW-1:0] e_data;
  logic [AW-1:0] e_raddr;
  logic          e_rvalid;

  always @(posedge clk) begin : model
    logic [NP-1:0] oldp;
    if (rst) begin
      m_valid = 1; m_pending = '0; m_last = NP - 1; m_owner = 0; m_age = 0;
      m_active = 0; m_issued = 0;
      for (int i = 0; i < NP; i++) m_addr[i] = '0;
      e_ov = '0; e_err = '0; e_data = '0; e_raddr = '0; e_rvalid = 0;
    end else begin
      oldp = m_pending;
      e_ov = '0; e_err = '0; e_rvalid = 0;
      if (!m_active) begin
        for (int k = 1; k <= NP; k++) begin
          if (!m_active && oldp[(m_last + k) % NP]) begin
            m_owner = (m_last + k) % NP; m_active = 1; m_issued = 0;
          end
        end
      end else if (!m_issued) begin
        if (!ram_busy) begin
          e_raddr = m_addr[m_owner]; e_rvalid = 1; m_issued = 1; m_age = 0;
        end
      end else begin
        m_age++;
        if (ram_out_valid) begin
          e_data = ram_data_out; e_ov[m_owner] = 1'b1;
          m_pending[m_owner] = 1'b0; m_last = m_owner; m_active = 0;
        end else if (m_age >= TO) begin
          e_err[m_owner] = 1'b1;
          m_pending[m_owner] = 1'b0; m_last = m_owner; m_active = 0;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (port_in_valid[i] && !oldp[i]) begin
          m_pending[i] = 1'b1; m_addr[i] = port_addr[i*AW +: AW];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_busy", port_busy, m_pending);
      chk("cmp_out_valid", port_out_valid, e_ov);
      chk("cmp_error", port_error, e_err);
      chk("cmp_data", port_data_out, e_data);
      chk("cmp_ram_addr", ram_addr, e_raddr);
      chk("cmp_ram_in_valid", ram_in_valid, e_rvalid);
    end
  end

  // Event logs for order checks.
  int iss_log[$];
  int ov_log[$];
  int err_log[$];
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      if (ram_in_valid === 1'b1) iss_log.push_back(int'(ram_addr));
      for (int i = 0; i < NP; i++) begin
        if (port_out_valid[i] === 1'b1) ov_log.push_back(i);
        if (port_error[i] === 1'b1) err_log.push_back(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic req(input int p, input logic [AW-1:0] a);
    port_addr[p*AW +: AW] = a;
    port_in_valid[p] = 1'b1;
    tick(1);
    port_in_valid = '0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (ram_in_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk("issue_seen", ram_in_valid, 1'b1);
  endtask

  task automatic serve(input int delay, input logic [DW-1:0] d, output int waited);
    wait_issue(waited);
    tick(delay);
    ram_data_out = d;
    ram_out_valid = 1'b1;
    tick(1);
    ram_out_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ib, ob, eb;
    tick(3);
    rst = 1'b0;
    chk("reset_busy", port_busy, 4'b0000);
    chk("reset_ram_in_valid", ram_in_valid, 1'b0);
    chk("reset_ram_addr", ram_addr, 23'h0);

    // Single request on port 2.
    ib = iss_log.size();
    req(2, 23'h123456);
    chk("t1_busy_after_req", port_busy, 4'b0100);
    serve(5, 8'hA5, w);
    chk("t1_req_to_issue", w, 2);
    chk("t1_out_valid", port_out_valid, 4'b0100);
    chk("t1_data", port_data_out, 8'hA5);
    chk("t1_busy_fall", port_busy, 4'b0000);
    tick(2);
    chk("t1_issue_count", iss_log.size() - ib, 1);
    chk("t1_issue_addr", iss_log[ib], 32'h123456);

    // Four simultaneous requests, then ports 0 and 3 with last_grant=3.
    do_reset();
    ib = iss_log.size(); ob = ov_log.size();
    port_addr = {23'h13, 23'h12, 23'h11, 23'h10};
    port_in_valid = 4'hF;
    tick(1);
    port_in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      serve(2, 8'h30 + 8'(k), w);
      if (k > 0) chk("t2_back_to_back", w, 2);
    end
    tick(1);
    chk("t2_ov_count", ov_log.size() - ob, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", ov_log[ob + k], k);
      chk("t2_issue_addr", iss_log[ib + k], 32'h10 + k);
    end
    ob = ov_log.size();
    port_in_valid = 4'b1001;
    tick(1);
    port_in_valid = '0;
    serve(1, 8'h40, w);
    serve(1, 8'h43, w);
    tick(1);
    chk("t2_wrap_count", ov_log.size() - ob, 2);
    chk("t2_wrap_first", ov_log[ob], 0);
    chk("t2_wrap_second", ov_log[ob + 1], 3);

    // RAM busy holds off the issue.
    ram_busy = 1'b1;
    req(1, 23'h0ABCDE);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("t3_held_off", ram_in_valid, 1'b0);
    end
    ram_busy = 1'b0;
    tick(1);
    chk("t3_issue_after_busy", ram_in_valid, 1'b1);
    chk("t3_issue_addr", ram_addr, 23'h0ABCDE);
    tick(1);
    chk("t3_single_pulse", ram_in_valid, 1'b0);
    ram_data_out = 8'h77;
    ram_out_valid = 1'b1;
    tick(1);
    ram_out_valid = 1'b0;
    chk("t3_out_valid", port_out_valid, 4'b0010);

    // Timeout on port 0.
    do_reset();
    eb = err_log.size(); ob = ov_log.size();
    req(0, 23'h42);
    wait_issue(w);
    for (int k = 0; k < TO - 1; k++) begin
      tick(1);
      chk("t4_no_early_error", port_error, 4'b0000);
    end
    tick(1);
    chk("t4_timeout_error", port_error, 4'b0001);
    chk("t4_busy_clear", port_busy, 4'b0000);
    chk("t4_data_kept", port_data_out, 8'h00);
    tick(3);
    ram_data_out = 8'h99;
    ram_out_valid = 1'b1;
    tick(1);
    ram_out_valid = 1'b0;
    chk("t4_late_rov_ignored", port_out_valid, 4'b0000);
    tick(2);
    chk("t4_err_count", err_log.size() - eb, 1);
    chk("t4_ov_count", ov_log.size() - ob, 0);

    // Repeated request while busy is dropped.
    ib = iss_log.size(); ob = ov_log.size();
    req(0, 23'h000001);
    req(0, 23'h7FFFFF);
    serve(3, 8'h5C, w);
    chk("t5_out_valid", port_out_valid, 4'b0001);
    tick(4);
    chk("t5_issue_count", iss_log.size() - ib, 1);
    chk("t5_issue_addr", iss_log[ib], 1);
    chk("t5_ov_count", ov_log.size() - ob, 1);

    // Reset one cycle into WAIT, then a stray ram_out_valid.
    ob = ov_log.size();
    req(3, 23'h333);
    wait_issue(w);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("t6_busy", port_busy, 4'b0000);
    chk("t6_out_valid", port_out_valid, 4'b0000);
    chk("t6_error", port_error, 4'b0000);
    chk("t6_data", port_data_out, 8'h00);
    chk("t6_ram_addr", ram_addr, 23'h0);
    chk("t6_ram_in_valid", ram_in_valid, 1'b0);
    rst = 1'b0;
    ram_data_out = 8'hEE;
    ram_out_valid = 1'b1;
    tick(1);
    ram_out_valid = 1'b0;
    chk("t6_stray_rov", port_out_valid, 4'b0000);
    tick(3);
    chk("t6_no_strobe", ov_log.size() - ob, 0);
    chk("t6_idle_busy", port_busy, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
